// File: rtl/mc_pkg.sv
// Shared microcontroller definitions: opcodes, execution unit indices, fault codes
// and the sequencer state encoding.
package mc_pkg;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_ALUI_A  = 4'h1;
    localparam logic [3:0] OP_ALUI_B  = 4'h2;
    localparam logic [3:0] OP_ALU_ADD = 4'h3;
    localparam logic [3:0] OP_ALU_SUB = 4'h4;
    localparam logic [3:0] OP_ALU_AND = 4'h5;
    localparam logic [3:0] OP_ALU_OR  = 4'h6;
    localparam logic [3:0] OP_MOV     = 4'h7;
    localparam logic [3:0] OP_LDI     = 4'h8;
    localparam logic [3:0] OP_HALT    = 4'hF;

    localparam int U_ALUI = 0;
    localparam int U_ALU  = 1;
    localparam int U_MOV  = 2;
    localparam int U_LDI  = 3;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_ILLEGAL  = 2'b01,
        FC_TIMEOUT  = 2'b10,
        FC_SPURIOUS = 2'b11
    } fault_code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DISPATCH,
        S_WAIT,
        S_RETIRE,
        S_HALT,
        S_FAULT
    } state_e;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode qualifier, shared by the sequencer and the execution FSMs.
module op_decode
    import mc_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [3:0] unit_oh,
    output logic       is_nop,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        unit_oh    = 4'b0000;
        is_nop     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP:                                        is_nop = 1'b1;
            OP_ALUI_A, OP_ALUI_B:                          unit_oh[U_ALUI] = 1'b1;
            OP_ALU_ADD, OP_ALU_SUB, OP_ALU_AND, OP_ALU_OR: unit_oh[U_ALU] = 1'b1;
            OP_MOV:                                        unit_oh[U_MOV] = 1'b1;
            OP_LDI:                                        unit_oh[U_LDI] = 1'b1;
            OP_HALT:                                       is_halt = 1'b1;
            default:                                       is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_seq_ctrl.sv
// Instruction sequencer: fetch, decode, dispatch to one execution FSM, wait, retire.
// Optional SINGLE_STEP_EN adds a `step` input that runs one instruction per rising edge.
//
// state    | meaning
// IDLE     | quiet, waiting for run (or a step edge)
// FETCH    | instr_req high until instr_valid
// DECODE   | opcode classified from the latched word
// DISPATCH | one-cycle exec_start pulse to the selected unit
// WAIT     | watchdog running, waiting for the unit's done
// RETIRE   | count the instruction, clear the bus
// HALT     | halted until run drops
// FAULT    | sticky fault until run goes 0 then 1
module instr_seq_ctrl
    import mc_pkg::*;
#(
    parameter int WDOG_CYCLES = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic             instr_valid,
    input  logic [15:0]      instr_word,
    output logic             instr_req,
    output logic [15:0]      fullBitNum,
    output logic [3:0]       exec_start,
    input  logic [3:0]       exec_done,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] retired_cnt
);

    state_e            state_q, state_d;
    logic [15:0]       instr_q, instr_d;
    logic [7:0]        wdog_q, wdog_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    fault_code_e       fault_code_q, fault_code_d;
    logic              fault_q, fault_d;
    logic              run_low_q, run_low_d;
    logic              step_mode_q, step_mode_d;
    logic              instr_req_q, instr_req_d;
    logic [3:0]        exec_start_q, exec_start_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              step_rise;

    logic [3:0] unit_oh;
    logic       is_nop, is_halt, is_illegal;

    op_decode u_op_decode (
        .opcode     (instr_q[15:12]),
        .unit_oh    (unit_oh),
        .is_nop     (is_nop),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

`ifdef SINGLE_STEP_EN
    logic step_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) step_prev_q <= 1'b0;
        else      step_prev_q <= step;
    end

    assign step_rise = step & ~step_prev_q;
`else
    assign step_rise = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        wdog_d       = wdog_q;
        retired_d    = retired_q;
        fault_code_d = fault_code_q;
        run_low_d    = run_low_q;
        step_mode_d  = step_mode_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end else if (step_rise) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b1;
                end
            end
            S_FETCH: begin
                if (!run && !step_mode_q) begin
                    state_d = S_IDLE;
                end else if (instr_valid) begin
                    instr_d = instr_word;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_nop) begin
                    state_d = S_RETIRE;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_illegal) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_ILLEGAL;
                end else begin
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                // The start cycle is watchdog cycle 1, so the count equals cycles since start.
                wdog_d  = 8'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + 8'd1;
                if (|(exec_done & unit_oh)) begin
                    state_d = S_RETIRE;
                end else if (|(exec_done & ~unit_oh)) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_SPURIOUS;
                end else if (wdog_d == 8'(WDOG_CYCLES)) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_TIMEOUT;
                end
            end
            S_RETIRE: begin
                if (run && !step_mode_q) state_d = S_FETCH;
                else                     state_d = S_IDLE;
            end
            S_HALT: begin
                if (!run) state_d = S_IDLE;
            end
            S_FAULT: begin
                if (!run) begin
                    run_low_d = 1'b1;
                end else if (run_low_q) begin
                    state_d      = S_FETCH;
                    fault_code_d = FC_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_RETIRE || state_d == S_HALT || state_d == S_FAULT) instr_d = 16'h0000;
        if (state_d == S_RETIRE) retired_d = retired_q + 1'b1;
        if (state_d != S_FAULT) run_low_d = 1'b0;
        if (state_d == S_IDLE || state_d == S_HALT || state_d == S_FAULT) step_mode_d = 1'b0;

        fault_d      = (state_d == S_FAULT);
        instr_req_d  = (state_d == S_FETCH);
        halted_d     = (state_d == S_HALT);
        busy_d       = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_DISPATCH) ||
                       (state_d == S_WAIT)  || (state_d == S_RETIRE);
        exec_start_d = (state_d == S_DISPATCH) ? unit_oh : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            instr_q      <= 16'h0000;
            wdog_q       <= 8'd0;
            retired_q    <= '0;
            fault_code_q <= FC_NONE;
            fault_q      <= 1'b0;
            run_low_q    <= 1'b0;
            step_mode_q  <= 1'b0;
            instr_req_q  <= 1'b0;
            exec_start_q <= 4'b0000;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            wdog_q       <= wdog_d;
            retired_q    <= retired_d;
            fault_code_q <= fault_code_d;
            fault_q      <= fault_d;
            run_low_q    <= run_low_d;
            step_mode_q  <= step_mode_d;
            instr_req_q  <= instr_req_d;
            exec_start_q <= exec_start_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
        end
    end

    assign instr_req   = instr_req_q;
    assign fullBitNum  = instr_q;
    assign exec_start  = exec_start_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
    assign retired_cnt = retired_q;

endmodule

// File: doc/instr_seq_ctrl.md
Name: instr_seq_ctrl

Overview:
Top-level instruction sequencer for the microcontroller. It fetches a 16-bit instruction word and holds it stable on the shared instruction bus. It decodes the opcode and starts exactly one execution FSM (ALUI, ALU, MOV or LDI) with a one-cycle start pulse. It then waits for that FSM's done pulse, retires the instruction and loops, with a watchdog and fault reporting.

Parameters:
WDOG_CYCLES, 32, max cycles from exec_start to matching done before TIMEOUT fault (valid range 2..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
run  in  1  level; 1 = sequence continuously
instr_valid  in  1  instruction memory word ready
instr_word  in  16  fetched instruction
instr_req  out  1  fetch request, held until instr_valid
fullBitNum  out  16  registered instruction broadcast to all execution FSMs
exec_start  out  4  one-hot start pulse: [0] ALUI, [1] ALU, [2] MOV, [3] LDI
exec_done  in  4  done pulses from execution FSMs, same bit order
busy  out  1  1 from FETCH through RETIRE
halted  out  1  1 while in HALT
fault  out  1  sticky fault flag
fault_code  out  2  00 none, 01 ILLEGAL, 10 TIMEOUT, 11 SPURIOUS
retired_cnt  out  CNT_W  count of retired instructions, wraps

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE; fullBitNum=16'h0000 (NOP).
  - instr_req, exec_start, busy, halted, fault = 0.
  - fault_code=00; retired_cnt=0; watchdog=0.
- Decode, on fullBitNum[15:12]:
  - 0000 NOP: no unit.
  - 0001, 0010: ALUI.
  - 0011-0110: ALU.
  - 0111: MOV.
  - 1000: LDI.
  - 1111: HALT.
  - All other opcodes: ILLEGAL.
- IDLE: outputs quiet. run=1 -> FETCH.
- FETCH: instr_req=1, busy=1.
  - On instr_valid: fullBitNum <= instr_word, -> DECODE.
  - run falling while in FETCH -> IDLE, no latch.
- DECODE (1 cycle):
  - NOP -> RETIRE.
  - HALT -> HALT.
  - ILLEGAL -> FAULT with code 01.
  - Otherwise -> DISPATCH.
- DISPATCH (1 cycle): exec_start[sel]=1 for exactly this cycle; watchdog cleared; -> WAIT.
- WAIT: watchdog increments each cycle. Checks are evaluated in this priority:
  1. exec_done[sel]=1 -> RETIRE. A matching done wins over a simultaneous watchdog expiry.
  2. Any other exec_done bit=1 -> FAULT with code 11.
  3. watchdog reaches WDOG_CYCLES -> FAULT with code 10.
- RETIRE (1 cycle):
  - retired_cnt+1, wrapping at 2^CNT_W.
  - fullBitNum <= 16'h0000, so the execution FSMs return to their idle state.
  - run=1 -> FETCH, else IDLE.
- HALT: halted=1; fullBitNum cleared to 0. run=0 -> IDLE, and halted drops in the same transition.
- FAULT:
  - fault=1; fault_code latched on entry; fullBitNum cleared; no further fetch.
  - Exit only by reset, or by run=0 followed by run=1: this clears fault/fault_code and goes to FETCH.
- fullBitNum is constant from the DECODE cycle until RETIRE/FAULT/HALT clears it.
- exec_start is never asserted outside DISPATCH; at most one bit is ever high.
- Reset mid-instruction: everything returns to reset values immediately. No exec_start glitch is allowed.

Optional Feature:
SINGLE_STEP_EN:
- Defined:
  - Adds input port `step` (1 bit).
  - In IDLE with run=0, a rising edge of step executes exactly one FETCH..RETIRE sequence, then returns to IDLE.
  - Edge detection uses a registered copy of step; that register resets to 0.
  - step is ignored outside IDLE.
- Undefined: no step port; sequencing is controlled by run only.

Decomposition:
- Shared package `mc_pkg` holds:
  - opcode constants (OP_NOP, OP_ALUI_A, OP_ALUI_B, OP_ALU_*, OP_MOV, OP_LDI, OP_HALT);
  - unit index constants (U_ALUI=0, U_ALU=1, U_MOV=2, U_LDI=3);
  - fault code constants;
  - state encoding.
- Sub-module `op_decode`: combinational, opcode -> {unit one-hot, is_nop, is_halt, is_illegal}. The execution FSMs reuse it for their own opcode qualification.

Test Plan:
1. run=1, instr_word=16'h1041 (ALUI), exec_done[0] returned 8 cycles after start:
   - exactly one exec_start=4'b0001 pulse;
   - fullBitNum=16'h1041 for the whole instruction, then 16'h0000;
   - retired_cnt=1; next FETCH follows.
2. instr_word=16'h9000 -> fault=1, fault_code=01; no exec_start ever; instr_req stays 0 afterwards.
3. ALU opcode 16'h3081 with exec_done withheld: fault_code=10 exactly WDOG_CYCLES cycles after the start pulse. Then toggle run 0->1: fault clears and a fetch resumes.
4. MOV dispatched (exec_start=4'b0100), exec_done=4'b0001 injected -> fault_code=11.
5. Sequence NOP, HALT: retired_cnt=1 and halted=1. run=0 -> IDLE, halted=0.
6. Assert rst=0 mid-WAIT, asynchronously between clock edges: all outputs reach reset values before the next edge; retired_cnt=0. With SINGLE_STEP_EN defined, one step pulse retires exactly one instruction.
